alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage ALU that consumes the 4-bit `alu_op` produced by the ALU control decoder, together with two operands, and returns a registered result with branch-compare flags. Add, sub, compare, logic, LUI and AUIPC complete in one cycle. Shifts run serially, one bit per cycle, to save area. Operands enter and results leave through valid/ready handshakes, so the unit sits between decode/operand-fetch and writeback/branch resolution.

## Interface
Reset is synchronous and active-high.

Parameters:
- `WIDTH`, default 32, datapath width.
- `SHAMT_W`, default `$clog2(WIDTH)`, shift-amount width.

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: unit can accept an operation.
- `alu_op` input 4: operation code, `alu_op_t` encoding.
- `op_a` input WIDTH: rs1 value, or PC for AUIPC.
- `op_b` input WIDTH: rs2 value or immediate; shift amount is `op_b[SHAMT_W-1:0]`.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `result` output WIDTH: registered result.
- `zero` output 1: `result == 0`, registered with `result`.

## Operation
- States: IDLE, SHIFT, DONE.
- Accept: `in_valid && in_ready`. Operands and op are captured at that edge; later input changes are ignored.
- `in_ready` = (state == IDLE) || (state == DONE && out_ready).
- Single-cycle ops: result registered at the accept edge, then state goes to DONE.
  - ADD: a+b.
  - SUB: a−b.
  - SLT: signed a<b, zero-extended.
  - SLTU: unsigned a<b.
  - XOR, OR, AND.
  - LUI: b.
  - AUIPC: a+b.
  - All arithmetic wraps modulo 2^WIDTH.
- Shifts (SLL/SRL/SRA):
  - On accept: load shift register with `op_a`, load counter with shamt.
  - If shamt == 0: go straight to DONE with result = `op_a`.
  - Otherwise go to SHIFT. Each cycle: shift one bit and decrement the counter. When the counter reaches 0, go to DONE.
  - SRL fills with 0. SRA fills with the captured `op_a[WIDTH-1]`.
- DONE:
  - `out_valid` = 1; `result` and `zero` are held stable until `out_ready`.
  - `out_ready` with no new accept → IDLE.
  - `out_ready` with a simultaneous accept → the new op starts, giving back-to-back issue.
- Unused codes 4'hC–4'hF: single-cycle, result 0, `zero` = 1.
- `rst`, at any time including mid-SHIFT: state IDLE, counter 0, `result` 0, `zero` 0, `out_valid` 0. Any in-flight op is discarded.

## Timing
- Reset values: `in_ready` 1, `out_valid` 0, `result` 0, `zero` 0.
- Latency is measured from the accept edge k.
  - Single-cycle op: `out_valid` in the cycle after edge k.
  - Shift by n: `out_valid` in the cycle after edge k+n, i.e. n+1 cycles. A shift of 0 takes 1 cycle.
  - Worst case: shift by 31 → 32 cycles.
- `in_ready` is low throughout SHIFT, and low in DONE while `out_ready` is low.
- Peak throughput: one single-cycle op per clock, via the DONE-with-`out_ready` path.
- `out_valid` never drops without `out_ready` or `rst`. Once `out_valid` is high, `result` may not change until the handshake completes.
- No combinational path from `in_valid`/`op_*` to `result`. `in_ready` depends combinationally on `out_ready` only.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum logic [3:0]: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, LUI=10, AUIPC=11.
  - `exec_state_t` enum for the state machine.
  - The ALU control decoder is switched to the same package, so both blocks share one encoding.
- One sub-module, `alu_shift_unit`: shift register, counter, direction/arith select, and a done pulse. The FSM, single-cycle datapath and output registers stay in `alu_exec_unit`.

## Test plan
- **ADD overflow:** ADD a=32'h7FFFFFFF, b=1, `out_ready`=1 → `result` 32'h80000000, `zero` 0, `out_valid` exactly 1 cycle after accept.
- **SUB to zero, then compares:** SUB 5,5 → `result` 0, `zero` 1. SLT a=32'hFFFFFFFF, b=1 → 1. SLTU with the same operands → 0.
- **Arithmetic shift:** SRA a=32'h80000000, b=4 → 32'hF8000000 after 5 cycles, with `in_ready` 0 for the whole SHIFT period. SLL a=1, b=32'h25 (shamt 5) → 32'h20. Shift with shamt 0 → `op_a`, 1 cycle.
- **Backpressure and back-to-back:** hold `out_ready` 0 for 3 cycles after XOR 0xF0^0xFF → `result` 32'h0F stable and `out_valid` held. Then assert `out_ready` with a new ADD presented the same cycle → ADD accepted and its result valid on the next cycle.
- **Reset mid-shift:** SLL by 31, assert `rst` on the 10th SHIFT cycle → next cycle `out_valid` 0, `result` 0, `in_ready` 1. A following ADD 2+3 → 5 with normal latency.
- **Upper-immediate and unused codes:** LUI b=32'h12345000 → 32'h12345000. AUIPC a=32'h1000, b=32'h2000 → 32'h3000. `alu_op` 4'hE → `result` 0, `zero` 1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : ALU operation encoding shared by the control decoder and exec unit
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    SLL   = 4'd2,
    SLT   = 4'd3,
    SLTU  = 4'd4,
    XOR   = 4'd5,
    SRL   = 4'd6,
    SRA   = 4'd7,
    OR    = 4'd8,
    AND   = 4'd9,
    LUI   = 4'd10,
    AUIPC = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } exec_state_t;

  function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
    return (op == SLL) || (op == SRL) || (op == SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_exec_unit_if : operand-in / result-out handshake bundle of the exec ALU
// Rev 1.0
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, alu_op, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_op, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_shift_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_shift_unit : serial one-bit-per-cycle shifter with down-counter
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               start,
  input  wire logic               left,
  input  wire logic               arith,
  input  wire logic [WIDTH-1:0]   data_in,
  input  wire logic [SHAMT_W-1:0] shamt,
  output logic                    done,
  output logic [WIDTH-1:0]        data_next
);

  logic [WIDTH-1:0]   r_data;
  logic [SHAMT_W-1:0] r_count;
  logic               r_left;
  logic               r_fill;

  // data_next is the value after the shift happening on the coming edge, so
  // the owner can register the final value in the same edge the count hits 0.
  always_comb begin
    data_next = r_left ? {r_data[WIDTH-2:0], 1'b0} : {r_fill, r_data[WIDTH-1:1]};
    done      = (r_count == SHAMT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_count <= '0;
      r_left  <= 1'b0;
      r_fill  <= 1'b0;
    end else if (start) begin
      r_data  <= data_in;
      r_count <= shamt;
      r_left  <= left;
      r_fill  <= arith & data_in[WIDTH-1];
    end else if (r_count != '0) begin
      r_data  <= data_next;
      r_count <= r_count - SHAMT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_exec_unit : execute-stage ALU, single-cycle ops plus serial shifts
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  wire logic      clk,
  input  wire logic      rst,
  alu_exec_unit_if.slave bus
);

  exec_state_t        r_state;
  exec_state_t        w_state_next;
  alu_op_t            w_op;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_is_shift;
  logic               w_accept;
  logic               w_shift_start;
  logic               w_shift_done;
  logic [WIDTH-1:0]   w_shift_next;
  logic [WIDTH-1:0]   w_single;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;

  always_comb begin
    w_op          = alu_op_t'(bus.alu_op);
    w_shamt       = bus.op_b[SHAMT_W-1:0];
    w_is_shift    = is_shift_op(bus.alu_op);
    w_accept      = bus.in_valid && bus.in_ready;
    w_shift_start = w_accept && w_is_shift && (w_shamt != '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept)
          w_state_next = w_shift_start ? ST_SHIFT : ST_DONE;
        else if (r_state == ST_DONE && bus.out_ready)
          w_state_next = ST_IDLE;
      end
      ST_SHIFT: if (w_shift_done) w_state_next = ST_DONE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE && bus.out_ready);
    bus.out_valid = (r_state == ST_DONE);
    bus.result    = r_result;
    bus.zero      = r_zero;
  end

  // Shift ops with shamt 0 fall through here and return op_a.
  always_comb begin
    w_single = '0;
    case (w_op)
      ADD, AUIPC:    w_single = bus.op_a + bus.op_b;
      SUB:           w_single = bus.op_a - bus.op_b;
      SLT:           w_single = {{(WIDTH-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
      SLTU:          w_single = {{(WIDTH-1){1'b0}}, bus.op_a < bus.op_b};
      XOR:           w_single = bus.op_a ^ bus.op_b;
      OR:            w_single = bus.op_a | bus.op_b;
      AND:           w_single = bus.op_a & bus.op_b;
      LUI:           w_single = bus.op_b;
      SLL, SRL, SRA: w_single = bus.op_a;
      default:       w_single = '0;
    endcase
  end

  alu_shift_unit #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .start     (w_shift_start),
    .left      (w_op == SLL),
    .arith     (w_op == SRA),
    .data_in   (bus.op_a),
    .shamt     (w_shamt),
    .done      (w_shift_done),
    .data_next (w_shift_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept && !w_shift_start) begin
      r_result <= w_single;
      r_zero   <= (w_single == '0);
    end else if (r_state == ST_SHIFT && w_shift_done) begin
      r_result <= w_shift_next;
      r_zero   <= (w_shift_next == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_exec_unit : directed vector table plus handshake / reset sequences
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
  import alu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[15];

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents an op and returns #1 after its accept edge; operands are then
  // scrambled so a unit that fails to capture them is caught.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.op_a     = a;
    bus.op_b     = b;
    #1;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed %b, expected 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_a     = ~a;
    bus.op_b     = ~b;
    bus.alu_op   = 4'hF;
  endtask

  task automatic run_op(input string name, input vec_t v);
    int lat = 1;
    issue(v.op, v.a, v.b);
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_result"}, bus.result, v.exp_result);
    chk({name, "_zero"}, {31'b0, bus.zero}, {31'b0, v.exp_zero});
    chk({name, "_latency"}, lat, v.exp_lat);
  endtask

  initial begin
    vecs[0]  = '{4'(ADD),   32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1};
    vecs[1]  = '{4'(SUB),   32'd5,        32'd5,        32'h0,        1'b1, 1};
    vecs[2]  = '{4'(SLT),   32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1};
    vecs[3]  = '{4'(SLTU),  32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1};
    vecs[4]  = '{4'(XOR),   32'hF0,       32'hFF,       32'h0F,       1'b0, 1};
    vecs[5]  = '{4'(OR),    32'hA0A0A0A0, 32'h0505050F, 32'hA5A5A5AF, 1'b0, 1};
    vecs[6]  = '{4'(AND),   32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1};
    vecs[7]  = '{4'(LUI),   32'hDEADBEEF, 32'h12345000, 32'h12345000, 1'b0, 1};
    vecs[8]  = '{4'(AUIPC), 32'h1000,     32'h2000,     32'h3000,     1'b0, 1};
    vecs[9]  = '{4'hE,      32'h1234,     32'h5678,     32'h0,        1'b1, 1};
    vecs[10] = '{4'(SLL),   32'h1,        32'h25,       32'h20,       1'b0, 6};
    vecs[11] = '{4'(SRL),   32'h12345678, 32'h20,       32'h12345678, 1'b0, 1};
    vecs[12] = '{4'(SRL),   32'h80000000, 32'h8,        32'h00800000, 1'b0, 9};
    vecs[13] = '{4'(SRA),   32'hFFFFFFF0, 32'h4,        32'hFFFFFFFF, 1'b0, 5};
    vecs[14] = '{4'(SRA),   32'h40000000, 32'h1F,       32'h0,        1'b1, 32};

    bus.in_valid  = 1'b0;
    bus.alu_op    = 4'h0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'h1);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("reset_result", bus.result, 32'h0);
    chk("reset_zero", {31'b0, bus.zero}, 32'h0);

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i]);

    // SRA by 4: in_ready must stay low for the four SHIFT cycles
    issue(4'(SRA), 32'h80000000, 32'h4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sra_in_ready_c%0d", i), {31'b0, bus.in_ready}, 32'h0);
      chk($sformatf("sra_out_valid_c%0d", i), {31'b0, bus.out_valid}, 32'h0);
      @(posedge clk); #1;
    end
    chk("sra_out_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("sra_result", bus.result, 32'hF8000000);

    // Drain, then backpressure on an XOR result
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(4'(XOR), 32'hF0, 32'hFF);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_out_valid_c%0d", i), {31'b0, bus.out_valid}, 32'h1);
      chk($sformatf("bp_result_c%0d", i), bus.result, 32'h0F);
      chk($sformatf("bp_in_ready_c%0d", i), {31'b0, bus.in_ready}, 32'h0);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.alu_op    = 4'(ADD);
    bus.op_a      = 32'd10;
    bus.op_b      = 32'd20;
    #1;
    chk("b2b_in_ready", {31'b0, bus.in_ready}, 32'h1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_out_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("b2b_result", bus.result, 32'd30);

    // Reset on the 10th SHIFT cycle of an SLL by 31
    @(posedge clk); #1;
    issue(4'(SLL), 32'h1, 32'd31);
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_pre_valid", {31'b0, bus.out_valid}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_mid_result", bus.result, 32'h0);
    chk("rst_mid_zero", {31'b0, bus.zero}, 32'h0);
    chk("rst_mid_in_ready", {31'b0, bus.in_ready}, 32'h1);
    run_op("post_rst_add", '{4'(ADD), 32'd2, 32'd3, 32'd5, 1'b0, 1});
    // The aborted shift must not reappear once the ADD drains
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        checks++; errors++;
        $display("FAIL stale_shift: out_valid got 1, expected 0");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
